// File: rtl/spi_shift_register.sv
// spi_shift_register
//   Serial data path of the SPI master. Consumes the baud generator's
//   one-cycle edge strobes, shifts a loaded transmit word out on mosi and
//   assembles the receive word sampled from miso on the opposite SCLK edge.
//
// Ports
//   PClk, PRESETn       system clock / async active-low reset
//   ss                  slave select (active low), transfer window while 0
//   send_data           1-cycle pulse: load data_mosi into the TX shifter
//   lsbfe, cpol, cpha   bit order and SPI mode
//   flag_low/flags_low  SCLK falling edge next cycle / one cycle earlier
//   flag_high/flags_high SCLK rising edge next cycle / one cycle earlier
//   data_mosi           parallel transmit word
//   miso                synchronised serial receive data
//   mosi                registered serial transmit data
//   data_miso           last complete received word
//   receive_data        1-cycle pulse when data_miso is updated
module spi_shift_register #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              PClk,
  input  logic              PRESETn,
  input  logic              ss,
  input  logic              send_data,
  input  logic              lsbfe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              flag_low,
  input  logic              flags_low,
  input  logic              flag_high,
  input  logic              flags_high,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              receive_data
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              sel, tx_strobe, rx_strobe;
  logic [DATA_W-1:0] tx_reg, rx_reg, rx_merged;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt, tx_idx, rx_idx;
  logic              tx_bit;

  // Transmit changes one cycle ahead of the sampling edge of the mode:
  // the "s" (early) strobe launches, the plain strobe samples.
  assign sel       = cpha ^ cpol;
  assign tx_strobe = sel ? flags_high : flags_low;
  assign rx_strobe = sel ? flag_low   : flag_high;

  assign tx_idx = lsbfe ? tx_cnt : LAST - tx_cnt;
  assign rx_idx = lsbfe ? rx_cnt : LAST - rx_cnt;

  // Decoded bit select / bit merge; avoids variable indexes wider than
  // the word.
  always_comb begin
    tx_bit    = 1'b0;
    rx_merged = rx_reg;
    for (int i = 0; i < DATA_W; i++) begin
      if (tx_idx == CNT_W'(i)) tx_bit       = tx_reg[i];
      if (rx_idx == CNT_W'(i)) rx_merged[i] = miso;
    end
  end

  // Transmit: a load always wins over a coincident strobe and works even
  // with ss high. The word is never shifted, so it repeats after the wrap.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_reg <= '0;
      tx_cnt <= '0;
      mosi   <= 1'b0;
    end else if (send_data) begin
      tx_reg <= data_mosi;
      tx_cnt <= '0;
    end else if (ss) begin
      tx_cnt <= '0;
    end else if (tx_strobe) begin
      mosi   <= tx_bit;
      tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + CNT_W'(1);
    end
  end

  // Receive: rx_reg is left alone on ss, but the counter restart means a
  // partial word is simply overwritten by the next full one.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_reg       <= '0;
      rx_cnt       <= '0;
      data_miso    <= '0;
      receive_data <= 1'b0;
    end else begin
      receive_data <= 1'b0;
      if (ss) begin
        rx_cnt <= '0;
      end else if (rx_strobe) begin
        rx_reg <= rx_merged;
        if (rx_cnt == LAST) begin
          rx_cnt       <= '0;
          data_miso    <= rx_merged;
          receive_data <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_register.sv
// tb_spi_shift_register
//   Directed bench for spi_shift_register. A queue-based model of the
//   serial stream is compared with the DUT outputs on every falling edge;
//   directed tests additionally pin literal bit sequences and words.
module tb_spi_shift_register;
  localparam int DATA_W = 8;

  logic PClk = 1'b0;
  logic PRESETn = 1'b0;
  logic ss = 1'b1, send_data = 1'b0, lsbfe = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic flag_low = 1'b0, flags_low = 1'b0, flag_high = 1'b0, flags_high = 1'b0;
  logic [DATA_W-1:0] data_mosi = '0;
  logic miso, miso_drv = 1'b0, loop_en = 1'b0;
  logic mosi, receive_data;
  logic [DATA_W-1:0] data_miso;

  int pass_cnt = 0, total_cnt = 0, pulse_cnt = 0;

  assign miso = loop_en ? mosi : miso_drv;

  spi_shift_register #(.DATA_W(DATA_W), .CNT_W(4)) dut (
    .PClk(PClk), .PRESETn(PRESETn), .ss(ss), .send_data(send_data),
    .lsbfe(lsbfe), .cpol(cpol), .cpha(cpha),
    .flag_low(flag_low), .flags_low(flags_low),
    .flag_high(flag_high), .flags_high(flags_high),
    .data_mosi(data_mosi), .miso(miso),
    .mosi(mosi), .data_miso(data_miso), .receive_data(receive_data)
  );

  always #5 PClk = ~PClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // TX: the word is turned into its transmission order once; each launch
  // pops the front bit and rotates it to the back. RX: sampled bits are
  // queued in arrival order and placed by bit order when the word is full.
  logic [DATA_W-1:0] m_tx_word = '0, m_data = '0;
  logic m_mosi = 1'b0, m_rcv = 1'b0;
  bit m_txq[$];
  bit m_rxq[$];

  function automatic void build_txq(input logic lsb);
    m_txq.delete();
    for (int k = 0; k < DATA_W; k++) m_txq.push_back(m_tx_word[lsb ? k : DATA_W-1-k]);
  endfunction

  always @(posedge PClk or negedge PRESETn) begin
    bit b;
    logic [DATA_W-1:0] w;
    logic txs, rxs;
    if (!PRESETn) begin
      m_tx_word = '0; m_data = '0; m_mosi = 1'b0; m_rcv = 1'b0;
      build_txq(lsbfe);
      m_rxq.delete();
    end else begin
      txs = (cpol ^ cpha) ? flags_high : flags_low;
      rxs = (cpol ^ cpha) ? flag_low : flag_high;
      m_rcv = 1'b0;
      if (send_data) begin
        m_tx_word = data_mosi;
        build_txq(lsbfe);
      end else if (ss) begin
        build_txq(lsbfe);
      end else if (txs) begin
        b = m_txq.pop_front();
        m_mosi = b;
        m_txq.push_back(b);
      end
      if (ss) m_rxq.delete();
      else if (rxs) begin
        m_rxq.push_back(miso);
        if (m_rxq.size() == DATA_W) begin
          w = '0;
          for (int k = 0; k < DATA_W; k++) w[lsbfe ? k : DATA_W-1-k] = m_rxq[k];
          m_data = w;
          m_rcv = 1'b1;
          m_rxq.delete();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge PClk) begin
    chk("mosi", {31'd0, mosi}, {31'd0, m_mosi});
    chk("data_miso", {24'd0, data_miso}, {24'd0, m_data});
    chk("receive_data", {31'd0, receive_data}, {31'd0, m_rcv});
    if (receive_data) pulse_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge PClk);
    @(negedge PClk);
  endtask

  // 0 flags_low, 1 flag_low, 2 flags_high, 3 flag_high, 4 idle
  task automatic strobe(input int which);
    flags_low  = (which == 0);
    flag_low   = (which == 1);
    flags_high = (which == 2);
    flag_high  = (which == 3);
    tick();
    flags_low = 1'b0; flag_low = 1'b0; flags_high = 1'b0; flag_high = 1'b0;
  endtask

  task automatic load(input logic [DATA_W-1:0] w);
    data_mosi = w; send_data = 1'b1;
    tick();
    send_data = 1'b0;
  endtask

  int exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int exp_81[8] = '{1, 0, 0, 0, 0, 0, 0, 1};
  int p0;

  initial begin
    // Reset state
    tick(); tick();
    chk("reset mosi", {31'd0, mosi}, 32'd0);
    chk("reset data_miso", {24'd0, data_miso}, 32'd0);
    chk("reset receive_data", {31'd0, receive_data}, 32'd0);
    PRESETn = 1'b1;
    tick();

    // Mode 0, MSB first, 0xA5
    cpol = 0; cpha = 0; lsbfe = 0;
    load(8'hA5);
    ss = 1'b0; tick();
    for (int i = 0; i < 8; i++) begin
      strobe(0);
      chk($sformatf("a5 bit%0d", i), {31'd0, mosi}, exp_a5[i]);
      tick();
    end

    // Loopback, cpha=1, LSB first, 0x3C
    ss = 1'b1; tick();
    cpol = 0; cpha = 1; lsbfe = 1; loop_en = 1'b1;
    load(8'h3C);
    ss = 1'b0; tick();
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      strobe(2); strobe(3); strobe(4); strobe(0); strobe(1);
    end
    chk("loop pulse", {31'd0, receive_data}, 32'd1);
    chk("loop data", {24'd0, data_miso}, 32'h3C);
    tick();
    chk("loop pulse width", {31'd0, receive_data}, 32'd0);
    chk("loop pulse count", pulse_cnt - p0, 32'd1);

    // Partial abort then a full word of ones
    loop_en = 1'b0; ss = 1'b1;
    cpol = 0; cpha = 0; lsbfe = 0; miso_drv = 1'b1;
    tick();
    ss = 1'b0; tick();
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin strobe(3); tick(); end
    chk("partial no pulse", pulse_cnt - p0, 32'd0);
    ss = 1'b1; tick();
    ss = 1'b0; tick();
    for (int i = 0; i < 7; i++) begin strobe(3); tick(); end
    strobe(3);
    chk("full pulse", {31'd0, receive_data}, 32'd1);
    chk("full data", {24'd0, data_miso}, 32'hFF);
    tick();
    chk("full pulse count", pulse_cnt - p0, 32'd1);

    // Load colliding with a launch strobe at tx_cnt=3
    ss = 1'b1; tick();
    load(8'hA5);
    ss = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin strobe(0); tick(); end
    chk("coll pre", {31'd0, mosi}, 32'd1);
    data_mosi = 8'h70; send_data = 1'b1; flags_low = 1'b1;
    tick();
    send_data = 1'b0; flags_low = 1'b0;
    chk("coll hold", {31'd0, mosi}, 32'd1);
    strobe(0);
    chk("coll bit0", {31'd0, mosi}, 32'd0);
    strobe(0);
    chk("coll bit1", {31'd0, mosi}, 32'd1);

    // Wrap: 16 launches of 0x81, then one more restarts the word
    ss = 1'b1; tick();
    load(8'h81);
    ss = 1'b0; tick();
    for (int i = 0; i < 16; i++) begin
      strobe(0);
      chk($sformatf("wrap bit%0d", i), {31'd0, mosi}, exp_81[i % 8]);
    end
    strobe(4);
    strobe(0);
    chk("wrap restart", {31'd0, mosi}, 32'd1);

    // Asynchronous reset mid-transfer (mosi=1, data_miso=0xFF before)
    flags_low = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    chk("async mosi", {31'd0, mosi}, 32'd0);
    chk("async data_miso", {24'd0, data_miso}, 32'd0);
    chk("async receive_data", {31'd0, receive_data}, 32'd0);
    flags_low = 1'b0;
    @(negedge PClk);
    PRESETn = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
